// File: rtl/core_run_harness.sv
// Run controller for the rvmyth core: reset sequencing, OUT-bus change log and pass/timeout detection.
// Define HARNESS_CYCLE_STAMP_EN to add the log_cycle port and store run_cycles with every log entry.
module core_run_harness #(
   parameter int OUT_W         = 10,
   parameter int RST_CYCLES    = 5,
   parameter int TIMEOUT       = 1000,
   parameter int STABLE_CYCLES = 4,
   parameter int DEPTH         = 16,
   parameter int CYC_W         = 16
) (
   input  logic             clk_pri,
   input  logic             reset,
   input  logic             start,
   input  logic [OUT_W-1:0] exp_val,
   input  logic [OUT_W-1:0] core_out,
   output logic             core_reset,
   output logic             log_valid,
   output logic [OUT_W-1:0] log_data,
`ifdef HARNESS_CYCLE_STAMP_EN
   output logic [CYC_W-1:0] log_cycle,
`endif
   input  logic             log_ready,
   output logic [CYC_W-1:0] run_cycles,
   output logic             done,
   output logic             pass,
   output logic             timeout,
   output logic             overflow
);

   // state      | meaning
   // S_IDLE     | core held in reset, waiting for start
   // S_RST_HOLD | core held in reset for RST_CYCLES cycles, prev sample tracks core_out
   // S_RUN      | core running, changes logged, match/timeout watched
   // S_DONE     | core halted, pass/timeout held, log can be drained

   localparam int AW = $clog2(DEPTH);
   localparam int HW = $clog2(RST_CYCLES + 1);
   localparam int MW = $clog2(STABLE_CYCLES + 1);
`ifdef HARNESS_CYCLE_STAMP_EN
   localparam int ENT_W = CYC_W + OUT_W;
`else
   localparam int ENT_W = OUT_W;
`endif

   localparam logic [HW-1:0]    HOLD_INIT   = HW'(RST_CYCLES - 1);
   localparam logic [HW-1:0]    HOLD_ONE    = HW'(1);
   localparam logic [MW-1:0]    MATCH_ONE   = MW'(1);
   localparam logic [MW-1:0]    MATCH_DONE  = MW'(STABLE_CYCLES);
   localparam logic [CYC_W-1:0] CYC_ONE     = CYC_W'(1);
   localparam logic [CYC_W-1:0] CYC_MAX     = '1;
   localparam logic [CYC_W-1:0] CYC_TIMEOUT = CYC_W'(TIMEOUT);
   localparam logic [AW:0]      PTR_ONE     = (AW + 1)'(1);

   typedef enum logic [1:0] {S_IDLE, S_RST_HOLD, S_RUN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [HW-1:0]    hold_q, hold_d;
   logic [CYC_W-1:0] run_q, run_d;
   logic [MW-1:0]    match_q, match_d, match_inc;
   logic [OUT_W-1:0] prev_q, prev_d;
   logic             pass_q, pass_d;
   logic             timeout_q, timeout_d;
   logic             ovf_q, ovf_d;
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [ENT_W-1:0] mem_q [DEPTH];
   logic [ENT_W-1:0] entry, head;
   logic             empty, full, pop, push_req, push, begin_run, is_match;

`ifdef HARNESS_CYCLE_STAMP_EN
   assign entry = {run_q, core_out};
`else
   assign entry = core_out;
`endif

   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop      = !empty && log_ready;
   assign push_req = (state_q == S_RUN) && (core_out != prev_q);
   // A full FIFO still accepts a push when the head leaves at the same edge.
   assign push     = push_req && (!full || pop);
   assign is_match = (core_out == exp_val);

   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      run_d     = run_q;
      match_d   = match_q;
      prev_d    = prev_q;
      pass_d    = pass_q;
      timeout_d = timeout_q;
      ovf_d     = ovf_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      begin_run = 1'b0;
      match_inc = match_q + MATCH_ONE;

      if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (push_req && full && !pop) ovf_d = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (start) begin_run = 1'b1;
         end
         S_RST_HOLD: begin
            prev_d = core_out;
            if (hold_q == '0) state_d = S_RUN;
            else hold_d = hold_q - HOLD_ONE;
         end
         S_RUN: begin
            prev_d = core_out;
            if (run_q != CYC_MAX) run_d = run_q + CYC_ONE;
            match_d = is_match ? match_inc : '0;
            // Match takes priority over timeout when both land on the same edge.
            if (is_match && (match_inc == MATCH_DONE)) begin
               state_d = S_DONE;
               pass_d  = 1'b1;
            end else if (run_d == CYC_TIMEOUT) begin
               state_d   = S_DONE;
               timeout_d = 1'b1;
            end
         end
         S_DONE: begin
            if (start) begin_run = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      if (begin_run) begin
         state_d   = S_RST_HOLD;
         hold_d    = HOLD_INIT;
         run_d     = '0;
         match_d   = '0;
         pass_d    = 1'b0;
         timeout_d = 1'b0;
         ovf_d     = 1'b0;
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
      end
   end

   always_ff @(posedge clk_pri) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         hold_q    <= '0;
         run_q     <= '0;
         match_q   <= '0;
         prev_q    <= '0;
         pass_q    <= 1'b0;
         timeout_q <= 1'b0;
         ovf_q     <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         run_q     <= run_d;
         match_q   <= match_d;
         prev_q    <= prev_d;
         pass_q    <= pass_d;
         timeout_q <= timeout_d;
         ovf_q     <= ovf_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk_pri) begin
      if (reset && push) mem_q[wr_ptr_q[AW-1:0]] <= entry;
   end

   assign head       = mem_q[rd_ptr_q[AW-1:0]];
   assign log_valid  = !empty;
   assign log_data   = head[OUT_W-1:0];
`ifdef HARNESS_CYCLE_STAMP_EN
   assign log_cycle  = head[ENT_W-1:OUT_W];
`endif
   assign core_reset = (state_q != S_RUN);
   assign run_cycles = run_q;
   assign done       = (state_q == S_DONE);
   assign pass       = pass_q;
   assign timeout    = timeout_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_core_run_harness.sv
// Bench for core_run_harness: directed run scenarios plus random traffic, all checked
// every cycle against a queue-based reference model of the run controller.
module tb_core_run_harness;

   localparam int OUT_W    = 10;
   localparam int RST_CYC  = 5;
   localparam int TMO      = 40;
   localparam int STABLE   = 4;
   localparam int DEPTH    = 16;
   localparam int CYC_W    = 16;

   logic             clk_pri = 1'b0;
   logic             reset;
   logic             start;
   logic [OUT_W-1:0] exp_val;
   logic [OUT_W-1:0] core_out;
   logic             log_ready;
   logic             core_reset, log_valid, done, pass, timeout, overflow;
   logic [OUT_W-1:0] log_data;
   logic [CYC_W-1:0] run_cycles;
`ifdef HARNESS_CYCLE_STAMP_EN
   logic [CYC_W-1:0] log_cycle;
`endif

   core_run_harness #(
      .OUT_W(OUT_W), .RST_CYCLES(RST_CYC), .TIMEOUT(TMO),
      .STABLE_CYCLES(STABLE), .DEPTH(DEPTH), .CYC_W(CYC_W)
   ) dut (
      .clk_pri    (clk_pri),
      .reset      (reset),
      .start      (start),
      .exp_val    (exp_val),
      .core_out   (core_out),
      .core_reset (core_reset),
      .log_valid  (log_valid),
      .log_data   (log_data),
`ifdef HARNESS_CYCLE_STAMP_EN
      .log_cycle  (log_cycle),
`endif
      .log_ready  (log_ready),
      .run_cycles (run_cycles),
      .done       (done),
      .pass       (pass),
      .timeout    (timeout),
      .overflow   (overflow)
   );

   always #5 clk_pri = ~clk_pri;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: the run is a phase plus plain counters; the log is a queue.
   localparam int P_IDLE = 0, P_HOLD = 1, P_RUN = 2, P_DONE = 3;
   typedef struct { int cyc; int val; } ent_t;
   ent_t m_q[$];
   int   m_phase = P_IDLE;
   int   m_hold = 0, m_run = 0, m_match = 0, m_prev = 0;
   bit   m_pass = 0, m_to = 0, m_ovf = 0;

   task automatic model_edge();
      bit   do_pop;
      bit   enter;
      ent_t e;
      if (!reset) begin
         m_phase = P_IDLE; m_q.delete(); m_run = 0; m_prev = 0; m_match = 0;
         m_hold = 0; m_pass = 0; m_to = 0; m_ovf = 0;
      end else begin
         do_pop = log_ready && (m_q.size() > 0);
         enter  = 0;
         if (do_pop) void'(m_q.pop_front());
         case (m_phase)
            P_IDLE, P_DONE: if (start) enter = 1;
            P_HOLD: begin
               m_prev = int'(core_out);
               m_hold++;
               if (m_hold == RST_CYC) m_phase = P_RUN;
            end
            default: begin
               if (int'(core_out) != m_prev) begin
                  if (m_q.size() < DEPTH) begin
                     e.cyc = m_run; e.val = int'(core_out);
                     m_q.push_back(e);
                  end else m_ovf = 1;
               end
               m_prev  = int'(core_out);
               m_match = (core_out == exp_val) ? m_match + 1 : 0;
               if (m_run < (1 << CYC_W) - 1) m_run++;
               if (m_match == STABLE) begin m_pass = 1; m_phase = P_DONE; end
               else if (m_run == TMO) begin m_to = 1; m_phase = P_DONE; end
            end
         endcase
         if (enter) begin
            m_phase = P_HOLD; m_hold = 0; m_q.delete(); m_run = 0; m_match = 0;
            m_pass = 0; m_to = 0; m_ovf = 0;
         end
      end
   endtask

   task automatic check_outputs();
      chk("core_reset", core_reset, m_phase != P_RUN);
      chk("done", done, m_phase == P_DONE);
      chk("pass", pass, m_pass);
      chk("timeout", timeout, m_to);
      chk("overflow", overflow, m_ovf);
      chk("run_cycles", run_cycles, m_run);
      chk("log_valid", log_valid, m_q.size() != 0);
      if (m_q.size() != 0) begin
         chk("log_data", log_data, m_q[0].val);
`ifdef HARNESS_CYCLE_STAMP_EN
         chk("log_cycle", log_cycle, m_q[0].cyc);
`endif
      end
   endtask

   task automatic tick();
      @(posedge clk_pri);
      model_edge();
      #1;
      check_outputs();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   int   cnt;
   int   seen[$];

   initial begin
      reset = 1'b0; start = 1'b0; exp_val = 10'd55; core_out = '0; log_ready = 1'b0;
      tick(); tick();
      chk("rst_core_reset", core_reset, 1);
      chk("rst_log_valid", log_valid, 0);
      reset = 1'b1;
      tick();

      // Start: core_reset held for exactly RST_CYC cycles.
      pulse_start();
      cnt = 0;
      while (core_reset && cnt < 20) begin cnt++; tick(); end
      chk("hold_len", cnt, RST_CYC);
      chk("run_start", run_cycles, 0);

      // Logging, ignored start in RUN, glitched match then pass.
      log_ready = 1'b1;
      for (int k = 0; k < TMO && !done; k++) begin
         core_out = (k < 2) ? 10'd0 : (k < 5) ? 10'd3 : (k < 10) ? 10'd7 :
                    (k == 12) ? 10'd1 : 10'd55;
         start = (k == 9);
         tick();
         start = 1'b0;
         if (k == 9) chk("start_in_run", core_reset, 0);
         if (log_valid) seen.push_back(int'(log_data));
      end
      chk("log_count", seen.size(), 5);
      if (seen.size() == 5) begin
         chk("log0", seen[0], 3);
         chk("log1", seen[1], 7);
         chk("log3", seen[3], 1);
      end
      chk("pass_flag", pass, 1);
      chk("pass_timeout", timeout, 0);
      chk("pass_done", done, 1);
      chk("pass_cycles", run_cycles, 17);

      // Timeout with overflow: change every cycle, no draining.
      log_ready = 1'b0; core_out = '0;
      pulse_start();
      repeat (RST_CYC) tick();
      for (int k = 0; k < TMO; k++) begin
         core_out = (k % 2 == 0) ? 10'd1 : 10'd0;
         tick();
         if (k == 15) chk("ovf_before", overflow, 0);
         if (k == 16) chk("ovf_after", overflow, 1);
      end
      chk("to_flag", timeout, 1);
      chk("to_pass", pass, 0);
      chk("to_cycles", run_cycles, TMO);
      log_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         chk("drain_valid", log_valid, 1);
         chk("drain_data", log_data, (i % 2 == 0) ? 1 : 0);
         tick();
      end
      chk("drain_empty", log_valid, 0);

      // Pass and timeout on the same edge.
      log_ready = 1'b0; core_out = '0;
      pulse_start();
      repeat (RST_CYC) tick();
      for (int k = 0; k < TMO; k++) begin
         core_out = (k >= TMO - STABLE) ? 10'd55 : OUT_W'(k % 2);
         tick();
      end
      chk("tie_pass", pass, 1);
      chk("tie_timeout", timeout, 0);
      chk("tie_done", done, 1);

      // Restart from DONE clears flags and log.
      pulse_start();
      chk("restart_pass", pass, 0);
      chk("restart_ovf", overflow, 0);
      chk("restart_valid", log_valid, 0);
      chk("restart_hold", core_reset, 1);

      // Reset mid-run.
      repeat (RST_CYC) tick();
      for (int k = 0; k < 4; k++) begin core_out = OUT_W'(k + 1); tick(); end
      core_out = 10'd9; reset = 1'b0;
      tick();
      chk("midrst_valid", log_valid, 0);
      chk("midrst_core_reset", core_reset, 1);
      chk("midrst_cycles", run_cycles, 0);
      reset = 1'b1;
      tick();

      // Random traffic.
      for (int n = 0; n < 3000; n++) begin
         reset     = ($urandom_range(299) != 0);
         start     = ($urandom_range(29) == 0);
         log_ready = ($urandom_range(2) != 0);
         if ($urandom_range(199) == 0) exp_val = OUT_W'($urandom_range(7));
         if ($urandom_range(3) == 0)
            core_out = ($urandom_range(1) == 0) ? exp_val : OUT_W'($urandom_range(7));
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
